// File: rtl/pkg_en.sv
// Shared token types and backpressure state
// for the mark_buff watermark buffer.
package pkg_en;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;

  typedef enum logic {
    FLOW  = 1'b0,
    STALL = 1'b1
  } bp_state_e;

endpackage

// File: rtl/mark_buff_ring_store.sv
// Circular token store: FIFO-ordered
// storage with occupancy count.
module ring_store
  import pkg_en::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = FTk_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   we_i,
  input  logic                   re_i,
  input  T                       wdata_i,
  output T                       head_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] num_o
);

  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW-1:0]  wp_q, wp_d;
  logic [AW-1:0]  rp_q, rp_d;
  logic [AW:0]    num_q, num_d;

  // Pointers wrap naturally: DEPTH is a power of two.
  always_comb begin
    wp_d  = wp_q + AW'(we_i);
    rp_d  = rp_q + AW'(re_i);
    num_d = num_q + (AW+1)'(we_i)
                  - (AW+1)'(re_i);
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      num_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      num_q <= num_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wp_q] <= wdata_i;
  end

  assign head_o  = mem_q[rp_q];
  assign empty_o = (num_q == '0);
  assign full_o  = (num_q == (AW+1)'(DEPTH));
  assign num_o   = num_q;

endmodule

// File: rtl/mark_buff.sv
// Watermark buffer with optional bypass,
// hysteretic backpressure and sticky overflow.
module mark_buff
  import pkg_en::*;
#(
  parameter int  DEPTH_BUFF = 8,
  parameter int  HIGH_MARK  = 5,
  parameter int  LOW_MARK   = 2,
  parameter int  BYPASS     = 1,
  parameter type TYPE_FWRD  = FTk_t
) (
  input  logic                        clock,
  input  logic                        reset,
  input  TYPE_FWRD                    I_FTk,
  output BTk_t                        O_BTk,
  output TYPE_FWRD                    O_FTk,
  input  BTk_t                        I_BTk,
  input  logic                        I_Flush,
  output logic                        O_Empty,
  output logic                        O_Full,
  output logic [$clog2(DEPTH_BUFF):0] O_Num,
  output logic                        O_Ovf
);

  localparam int NW = $clog2(DEPTH_BUFF) + 1;
  localparam logic [NW-1:0] HI = NW'(HIGH_MARK);
  localparam logic [NW-1:0] LO = NW'(LOW_MARK);

  if (DEPTH_BUFF < 4 ||
      (DEPTH_BUFF & (DEPTH_BUFF - 1)) != 0) begin : g_bad_depth
    $fatal(1, "DEPTH_BUFF must be pow2 >= 4");
  end
  if (LOW_MARK >= HIGH_MARK ||
      HIGH_MARK > DEPTH_BUFF - 3) begin : g_bad_marks
    $fatal(1, "need LOW < HIGH <= DEPTH-3");
  end

  logic      re, byp, we;
  TYPE_FWRD  head;
  bp_state_e state_q, state_d;
  logic      ovf_q, ovf_d;

  ring_store #(
    .DEPTH (DEPTH_BUFF),
    .T     (TYPE_FWRD)
  ) u_store (
    .clk_i   (clock),
    .rst_i   (reset),
    .flush_i (I_Flush),
    .we_i    (we),
    .re_i    (re),
    .wdata_i (I_FTk),
    .head_o  (head),
    .empty_o (O_Empty),
    .full_o  (O_Full),
    .num_o   (O_Num)
  );

  // Read, bypass and write qualifiers; output mux.
  always_comb begin
    re  = ~O_Empty & ~I_BTk.n & ~I_Flush;
    byp = (BYPASS != 0) & O_Empty & I_FTk.v
        & ~I_BTk.n & ~I_Flush;
    we  = I_FTk.v & ~byp & ~I_Flush
        & (~O_Full | re);
    O_FTk = '0;
    if (re)       O_FTk = head;
    else if (byp) O_FTk = I_FTk;
  end

  // Backpressure next state and overflow capture.
  always_comb begin
    state_d = state_q;
    ovf_d   = ovf_q | (I_FTk.v & O_Full & ~re);
    unique case (state_q)
      FLOW:  if (O_Num >= HI) state_d = STALL;
      STALL: if (O_Num <= LO) state_d = FLOW;
      default: state_d = FLOW;
    endcase
    if (I_Flush) begin
      state_d = FLOW;
      ovf_d   = 1'b0;
    end
  end

  // State and sticky-overflow registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FLOW;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // Back token: stall from FSM, rest passes through.
  always_comb begin
    O_BTk   = I_BTk;
    O_BTk.n = (state_q == STALL);
  end

  assign O_Ovf = ovf_q;

endmodule

// File: tb/tb_mark_buff.sv
// Self-checking bench for mark_buff using a
// queue-based reference model.
module tb_mark_buff;
  import pkg_en::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  FTk_t ift = '0;
  BTk_t ibt = '0;

  BTk_t obt_a, obt_b;
  FTk_t oft_a, oft_b;
  logic emp_a, emp_b, ful_a, ful_b;
  logic ovf_a, ovf_b;
  logic [3:0] num_a, num_b;

  always #5 clk = ~clk;

  mark_buff u_dut (
    .clock(clk), .reset(rst),
    .I_FTk(ift), .O_BTk(obt_a),
    .O_FTk(oft_a), .I_BTk(ibt),
    .I_Flush(flush), .O_Empty(emp_a),
    .O_Full(ful_a), .O_Num(num_a),
    .O_Ovf(ovf_a)
  );

  mark_buff #(.BYPASS(0)) u_nb (
    .clock(clk), .reset(rst),
    .I_FTk(ift), .O_BTk(obt_b),
    .O_FTk(oft_b), .I_BTk(ibt),
    .I_Flush(flush), .O_Empty(emp_b),
    .O_Full(ful_b), .O_Num(num_b),
    .O_Ovf(ovf_b)
  );

  int n_run = 0;
  int n_fail = 0;
  int sel = 0;
  FTk_t q[$];
  logic m_ovf = 1'b0;
  logic m_stall = 1'b0;
  logic m_re;
  FTk_t exp_ft, obs_ft;
  BTk_t obs_bt;

  task automatic cyc(input logic v,
                     input logic [7:0] d,
                     input logic n,
                     input logic fl);
    logic byp;
    int sz;
    ift.v = v;
    ift.d = d;
    ibt.n = n;
    ibt.t = 1'($urandom);
    ibt.v = 1'($urandom);
    ibt.c = 1'($urandom);
    flush = fl;
    #1;
    sz = q.size();
    m_re = (sz != 0) && !n && !fl;
    byp = (sel == 0) && (sz == 0) && v
        && !n && !fl;
    exp_ft = '0;
    if (m_re) exp_ft = q[0];
    else if (byp) exp_ft = ift;
    obs_ft = (sel != 0) ? oft_b : oft_a;
    obs_bt = (sel != 0) ? obt_b : obt_a;
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_stall = 1'b0;
    end else begin
      if (m_stall && sz <= 2) m_stall = 1'b0;
      else if (!m_stall && sz >= 5)
        m_stall = 1'b1;
      if (m_re) void'(q.pop_front());
      if (v && !byp) begin
        if (q.size() < 8) q.push_back(ift);
        else m_ovf = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    ift = '0;
    ibt = '0;
    flush = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    m_stall = 1'b0;
  endtask

  task automatic test_reset();
    sel = 0;
    do_reset();
    #1;
    n_run += 6;
    if (emp_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_empty got %b want 1", emp_a);
    end
    if (ful_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_full got %b want 0", ful_a);
    end
    if (num_a !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_num got %0d want 0", num_a);
    end
    if (obt_a.n !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_btk got %b want 0", obt_a.n);
    end
    if (oft_a !== 9'h0) begin
      n_fail++;
      $display("FAIL rst_ftk got %h want 0", oft_a);
    end
    if (ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ovf got %b want 0", ovf_a);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] toks [2];
    FTk_t want;
    toks[0] = 8'hA5;
    toks[1] = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      want = '{v: 1'b1, d: toks[i]};
      cyc(1'b1, toks[i], 1'b0, 1'b0);
      n_run += 2;
      if (obs_ft !== want) begin
        n_fail++;
        $display("FAIL byp_ftk got %h want %h",
                 obs_ft, want);
      end
      if (num_a !== 4'd0) begin
        n_fail++;
        $display("FAIL byp_num got %0d want 0", num_a);
      end
    end
  endtask

  task automatic test_watermark();
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
    n_run++;
    if (num_a !== 4'd5) begin
      n_fail++;
      $display("FAIL wm_num got %0d want 5", num_a);
    end
    cyc(1'b0, 8'h0, 1'b1, 1'b0);
    n_run++;
    if (obt_a.n !== 1'b1) begin
      n_fail++;
      $display("FAIL wm_stall got %b want 1", obt_a.n);
    end
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 8'h0, 1'b0, 1'b0);
      n_run += 3;
      if (obs_ft !== exp_ft) begin
        n_fail++;
        $display("FAIL wm_ftk got %h want %h",
                 obs_ft, exp_ft);
      end
      if (num_a !== 4'(q.size())) begin
        n_fail++;
        $display("FAIL wm_num got %0d want %0d",
                 num_a, q.size());
      end
      if (obt_a.n !== m_stall) begin
        n_fail++;
        $display("FAIL wm_btk got %b want %b",
                 obt_a.n, m_stall);
      end
    end
  endtask

  task automatic test_full_ovf();
    cyc(1'b0, 8'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    n_run += 2;
    if (ful_a !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_full got %b want 1", ful_a);
    end
    if (ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_early got %b want 0", ovf_a);
    end
    cyc(1'b1, 8'h48, 1'b1, 1'b0);
    n_run += 2;
    if (ovf_a !== 1'b1 || m_ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set got %b want 1", ovf_a);
    end
    if (num_a !== 4'd8) begin
      n_fail++;
      $display("FAIL ovf_num got %0d want 8", num_a);
    end
    cyc(1'b1, 8'h49, 1'b0, 1'b1);
    n_run += 3;
    if (obs_ft !== 9'h0) begin
      n_fail++;
      $display("FAIL fl_ftk got %h want 0", obs_ft);
    end
    if (num_a !== 4'd0) begin
      n_fail++;
      $display("FAIL fl_num got %0d want 0", num_a);
    end
    if (ovf_a !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_ovf got %b want 0", ovf_a);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1'b0, 8'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      n_run += 3;
      if (num_a !== 4'd8) begin
        n_fail++;
        $display("FAIL b2b_num got %0d want 8", num_a);
      end
      if (obs_ft !== exp_ft) begin
        n_fail++;
        $display("FAIL b2b_ftk got %h want %h",
                 obs_ft, exp_ft);
      end
      if (ovf_a !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_ovf got %b want 0", ovf_a);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b0, 8'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
    n_run++;
    if (num_a !== 4'd4) begin
      n_fail++;
      $display("FAIL rm_pre got %0d want 4", num_a);
    end
    ift = '{v: 1'b1, d: 8'hEE};
    flush = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    flush = 1'b0;
    ift = '0;
    ibt = '0;
    q.delete();
    m_ovf = 1'b0;
    m_stall = 1'b0;
    #1;
    n_run += 4;
    if (num_a !== 4'd0) begin
      n_fail++;
      $display("FAIL rm_num got %0d want 0", num_a);
    end
    if (emp_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_empty got %b want 1", emp_a);
    end
    if (obt_a.n !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_btk got %b want 0", obt_a.n);
    end
    if (oft_a !== 9'h0) begin
      n_fail++;
      $display("FAIL rm_ftk got %h want 0", oft_a);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic v, n, fl;
    for (int i = 0; i < 200; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      n  = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 31) == 0);
      cyc(v, 8'($urandom), n, fl);
      n_run += 5;
      if (obs_ft !== exp_ft) begin
        n_fail++;
        $display("FAIL rnd_ftk got %h want %h",
                 obs_ft, exp_ft);
      end
      if ({obs_bt.t, obs_bt.v, obs_bt.c}
          !== {ibt.t, ibt.v, ibt.c}) begin
        n_fail++;
        $display("FAIL rnd_pass got %b want %b",
                 obs_bt, ibt);
      end
      if (num_a !== 4'(q.size())) begin
        n_fail++;
        $display("FAIL rnd_num got %0d want %0d",
                 num_a, q.size());
      end
      if (obt_a.n !== m_stall) begin
        n_fail++;
        $display("FAIL rnd_btk got %b want %b",
                 obt_a.n, m_stall);
      end
      if (ovf_a !== m_ovf) begin
        n_fail++;
        $display("FAIL rnd_ovf got %b want %b",
                 ovf_a, m_ovf);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] ins[$];
    logic [7:0] outs[$];
    logic v, n;
    int bad;
    sel = 1;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      v = (i < 30) && ($urandom_range(0, 3) != 0);
      n = (i < 30) && ($urandom_range(0, 1) == 0);
      cyc(v, 8'(i + 1), n, 1'b0);
      if (v && q.size() != 0 &&
          q[q.size()-1].d == 8'(i + 1))
        ins.push_back(8'(i + 1));
      if (obs_ft.v) outs.push_back(obs_ft.d);
      n_run += 2;
      if (obs_ft !== exp_ft) begin
        n_fail++;
        $display("FAIL wrap_ftk got %h want %h",
                 obs_ft, exp_ft);
      end
      if (num_b !== 4'(q.size())) begin
        n_fail++;
        $display("FAIL wrap_num got %0d want %0d",
                 num_b, q.size());
      end
    end
    bad = (ins.size() != outs.size()) ? 1 : 0;
    if (bad == 0)
      foreach (ins[k])
        if (ins[k] !== outs[k]) bad++;
    n_run++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wrap_seq got %0d outs want %0d",
               outs.size(), ins.size());
    end
    sel = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_bypass();
    test_watermark();
    test_full_ovf();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
